multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control FSM plus ALU decoder that sequences the shared-resource RV32I datapath one instruction at a time over 3–5 cycles.
- Supported instructions: lw, sw, R-type, I-type ALU, beq, jal.
- Drives the datapath mux selects and write enables from the decoded opcode and the ALU Zero flag.
- Counts retired instructions and traps on illegal opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST_N  in  1  asynchronous, active-low reset
- op  in  7  Instr[6:0] from the instruction register
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  data write strobe
- IRWrite  out  1  instruction and OldPC register enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1
- ALUSrcB  out  2  00=rd2, 01=ImmExt, 10=const 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- trap  out  1  sticky illegal-opcode flag
- instr_done  out  1  one-cycle retire pulse
- retired  out  CNT_W  retired-instruction count

Behaviour:
- State register is 4 bits; outputs are Moore (functions of state), except:
  - PCWrite = PCUpdate | (Branch & Zero)
  - ImmSrc is decoded combinationally from op in every state.
- Reset:
  - Asynchronous to FETCH; trap=0, retired=0, instr_done=0.
  - While RST_N=0, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0; other outputs take their FETCH values.
- ImmSrc decode:
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - all other opcodes → 00
- States and outputs (unlisted enables are 0; ALUOp 00=add, 01=sub, 10=funct):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1 → DECODE
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
    - lw or sw → MEMADR
    - R-type → EXECR
    - I-type ALU → EXECI
    - beq → BEQ
    - jal → JAL
    - anything else → TRAP
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 → MEMREAD if lw, MEMWR if sw
  - MEMREAD: ResultSrc=00, AdrSrc=1 → MEMWB
  - MEMWB: ResultSrc=01, RegWrite=1 → FETCH
  - MEMWR: ResultSrc=00, AdrSrc=1, MemWrite=1 → FETCH
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB
  - ALUWB: ResultSrc=00, RegWrite=1 → FETCH
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 → FETCH
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 → ALUWB
  - TRAP: all enables 0, trap=1. Stays in TRAP until reset; no further fetches.
  - Unused state encodings → FETCH next cycle, no enables asserted.
- ALU decoder:
  - ALUOp 00 → add; ALUOp 01 → sub.
  - ALUOp 10, by funct3:
    - 000 → sub if op[5] & funct7b5, else add
    - 010 → slt
    - 110 → or
    - 111 → and
    - other funct3 → add (no trap)
- Latency (FETCH to next FETCH):
  - lw 5 cycles
  - sw, R-type, I-type, jal 4 cycles
  - beq 3 cycles
- Retire:
  - instr_done is registered and pulses for exactly the first FETCH cycle after leaving MEMWB, MEMWR, ALUWB or BEQ.
  - jal retires via ALUWB.
  - retired increments on the same edge and wraps modulo 2^CNT_W.
- Boundary cases:
  - beq not taken (Zero=0): PC keeps PC+4 from FETCH.
  - Reset asserted mid-instruction: aborts immediately; no partial write is issued after RST_N falls.

Test Plan:
- Reset release with op=0110011, funct3=000, funct7b5=0 → visits FETCH, DECODE, EXECR, ALUWB over 4 cycles. Checks:
  - IRWrite=1 only in cycle 0
  - ALUControl=000 in EXECR
  - RegWrite=1 in cycle 3
  - instr_done=1 in cycle 4, retired=1
- lw (0000011) then sw (0100011) →
  - lw: AdrSrc=1 in cycles 3–4, ResultSrc=01 with RegWrite in cycle 4.
  - sw: MemWrite=1 for exactly one cycle in cycle 3.
  - retired=2 after 9 cycles.
- beq, funct3=000:
  - Zero=1 → PCWrite=1 in BEQ, ALUControl=001.
  - Zero=0 → PCWrite=0 in BEQ.
  - Both cases: 3 cycles, instr_done pulses.
- R-type funct7b5=1, funct3=000 → sub (001); same inputs with op=0010011 → add (000); funct3=111 → 010; funct3=010 → 101.
- op=1111111 → TRAP after DECODE; trap=1 sticky for 20 cycles with all enables 0 and retired frozen; RST_N low releases it to FETCH with trap=0.
- RST_N pulsed low in MEMWR cycle → MemWrite falls asynchronously; state returns to FETCH; retired=0.

Source files
------------

// File: rtl/multicycle_controller.sv
`timescale 1ns/1ps
// Purpose : main control FSM + ALU decoder sequencing a shared-resource RV32I datapath.
// Latency : lw 5 cycles; sw, R-type, I-type, jal 4 cycles; beq 3 cycles (FETCH to FETCH).
// Backpr. : none; one instruction at a time, datapath never stalls the controller.
//
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   op, funct3, funct7b5  instruction fields from the instruction register
//   Zero                  ALU zero flag (qualifies the beq PC write)
//   PCWrite .. ImmSrc     datapath enables and mux selects
//   trap                  set while parked on an illegal opcode, cleared only by reset
//   instr_done, retired   one-cycle retire pulse and retired-instruction count
module multicycle_controller #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [6:0]       op,
   input  logic [2:0]       funct3,
   input  logic             funct7b5,
   input  logic             Zero,
   output logic             PCWrite,
   output logic             AdrSrc,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegWrite,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [2:0]       ALUControl,
   output logic [1:0]       ImmSrc,
   output logic             trap,
   output logic             instr_done,
   output logic [CNT_W-1:0] retired
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMREAD = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECR   = 4'd6,
      S_EXECI   = 4'd7,
      S_ALUWB   = 4'd8,
      S_BEQ     = 4'd9,
      S_JAL     = 4'd10,
      S_TRAP    = 4'd11
   } state_t;

   state_t           state_q, state_d;
   logic             instr_done_q, instr_done_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   // Raw Moore outputs before reset gating
   logic       pc_update, branch, adr_src, mem_write, ir_write, reg_write, in_trap;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
   logic       retire;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Next state and Moore outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = S_FETCH;
      pc_update  = 1'b0;
      branch     = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      in_trap    = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      case (state_q)
         S_FETCH: begin
            ir_write   = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            pc_update  = 1'b1;
            state_d    = S_DECODE;
         end
         S_DECODE: begin
            // Precompute the branch target into ALUOut while decoding
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_d   = (op == OP_SW) ? S_MEMWR : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            // Address stays on ALUOut through writeback; memory is idle here
            adr_src    = 1'b1;
            result_src = 2'b01;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
            state_d   = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_BEQ: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            branch    = 1'b1;
            state_d   = S_FETCH;
         end
         S_JAL: begin
            // PC <- target held in ALUOut; ALU forms OldPC+4 as the link value
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_update = 1'b1;
            state_d   = S_ALUWB;
         end
         S_TRAP: begin
            in_trap = 1'b1;
            state_d = S_TRAP;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // ------------------------------------------------------------------
   // Retire pulse and counter: every retiring state exits straight to FETCH
   // ------------------------------------------------------------------
   assign retire = (state_q == S_MEMWB) || (state_q == S_MEMWR) ||
                   (state_q == S_ALUWB) || (state_q == S_BEQ);

   always_comb begin
      instr_done_d = retire;
      retired_d    = retired_q;
      if (retire) begin
         retired_d = retired_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         instr_done_q <= 1'b0;
         retired_q    <= '0;
      end else begin
         instr_done_q <= instr_done_d;
         retired_q    <= retired_d;
      end
   end

   // ------------------------------------------------------------------
   // ALU decoder
   // ------------------------------------------------------------------
   always_comb begin
      ALUControl = 3'b000;
      case (alu_op)
         2'b01: ALUControl = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

   // Immediate format depends only on the opcode, in every state
   always_comb begin
      case (op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs: write enables are gated by RST_N so asserting reset kills
   // any in-flight write without waiting for a clock edge.
   // ------------------------------------------------------------------
   assign PCWrite    = RST_N & (pc_update | (branch & Zero));
   assign IRWrite    = RST_N & ir_write;
   assign RegWrite   = RST_N & reg_write;
   assign MemWrite   = RST_N & mem_write;
   assign AdrSrc     = adr_src;
   assign ResultSrc  = result_src;
   assign ALUSrcA    = alu_src_a;
   assign ALUSrcB    = alu_src_b;
   assign trap       = in_trap;
   assign instr_done = instr_done_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
`timescale 1ns/1ps
// Directed bench for multicycle_controller: instruction walks, ALU decode, trap, mid-instruction reset.
module tb_multicycle_controller;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [6:0]  op = OP_R;
   logic [2:0]  funct3 = 3'b000;
   logic        funct7b5 = 1'b0;
   logic        Zero = 1'b0;
   logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0]  ALUControl;
   logic        trap, instr_done;
   logic [31:0] retired;

   int errs   = 0;
   int checks = 0;
   int n;

   multicycle_controller #(.CNT_W(32)) dut (
      .CLK(CLK), .RST_N(RST_N), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
      .ImmSrc(ImmSrc), .trap(trap), .instr_done(instr_done), .retired(retired)
   );

   always #10 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to the middle of the next cycle (outputs settled, far from posedge)
   task automatic nxt;
      @(negedge CLK);
      #1;
   endtask

   // Reset with the given instruction fields; returns sampling cycle 0 (FETCH)
   task automatic do_reset(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      @(negedge CLK);
      RST_N = 1'b0; op = o; funct3 = f3; funct7b5 = f7; Zero = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      #1;
   endtask

   // Cycles from the current FETCH until IRWrite shows the next FETCH
   task automatic fetch_gap(output int cnt);
      cnt = 0;
      do begin
         nxt();
         cnt++;
      end while (IRWrite !== 1'b1 && cnt < 12);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // ---------------- reset state ----------------
      @(negedge CLK); @(negedge CLK); #1;
      chk("rst_irwrite",   IRWrite,    0);
      chk("rst_pcwrite",   PCWrite,    0);
      chk("rst_regwrite",  RegWrite,   0);
      chk("rst_memwrite",  MemWrite,   0);
      chk("rst_trap",      trap,       0);
      chk("rst_retired",   retired,    0);
      chk("rst_done",      instr_done, 0);
      chk("rst_alusrcb",   ALUSrcB,    2);
      chk("rst_resultsrc", ResultSrc,  2);
      @(negedge CLK); RST_N = 1'b1; #1;

      // ---------------- R-type add ----------------
      chk("r_c0_irwrite", IRWrite, 1);
      chk("r_c0_pcwrite", PCWrite, 1);
      chk("r_c0_adrsrc",  AdrSrc,  0);
      nxt();
      chk("r_c1_irwrite", IRWrite, 0);
      chk("r_c1_srca",    ALUSrcA, 1);
      chk("r_c1_srcb",    ALUSrcB, 1);
      nxt();
      chk("r_c2_aluctl",  ALUControl, 0);
      chk("r_c2_srca",    ALUSrcA, 2);
      chk("r_c2_srcb",    ALUSrcB, 0);
      chk("r_c2_regwr",   RegWrite, 0);
      nxt();
      chk("r_c3_regwr",   RegWrite, 1);
      chk("r_c3_res",     ResultSrc, 0);
      chk("r_c3_irwrite", IRWrite, 0);
      nxt();
      chk("r_c4_done",    instr_done, 1);
      chk("r_c4_retired", retired, 1);
      chk("r_c4_irwrite", IRWrite, 1);
      nxt();
      chk("r_c5_done",    instr_done, 0);

      // ---------------- lw then sw ----------------
      do_reset(OP_LW, 3'b010, 1'b0);
      chk("lw_imm", ImmSrc, 0);
      nxt(); nxt();
      chk("lw_c2_srca",   ALUSrcA, 2);
      chk("lw_c2_srcb",   ALUSrcB, 1);
      chk("lw_c2_adr",    AdrSrc, 0);
      nxt();
      chk("lw_c3_adr",    AdrSrc, 1);
      chk("lw_c3_res",    ResultSrc, 0);
      chk("lw_c3_regwr",  RegWrite, 0);
      nxt();
      chk("lw_c4_adr",    AdrSrc, 1);
      chk("lw_c4_res",    ResultSrc, 1);
      chk("lw_c4_regwr",  RegWrite, 1);
      nxt();
      chk("lw_c5_fetch",  IRWrite, 1);
      chk("lw_c5_done",   instr_done, 1);
      chk("lw_c5_ret",    retired, 1);
      op = OP_SW; #1;
      chk("sw_imm", ImmSrc, 1);
      nxt();
      chk("sw_c6_mw", MemWrite, 0);
      nxt();
      chk("sw_c7_mw", MemWrite, 0);
      nxt();
      chk("sw_c8_mw",  MemWrite, 1);
      chk("sw_c8_adr", AdrSrc, 1);
      nxt();
      chk("sw_c9_mw",    MemWrite, 0);
      chk("sw_c9_fetch", IRWrite, 1);
      chk("sw_c9_done",  instr_done, 1);
      chk("sw_c9_ret",   retired, 2);

      // ---------------- beq taken / not taken ----------------
      do_reset(OP_BEQ, 3'b000, 1'b0);
      Zero = 1'b1; #1;
      chk("beq_imm", ImmSrc, 2);
      nxt();
      chk("beq_dec_pcw", PCWrite, 0);
      nxt();
      chk("beqt_pcw",    PCWrite, 1);
      chk("beqt_aluctl", ALUControl, 1);
      chk("beqt_srca",   ALUSrcA, 2);
      chk("beqt_srcb",   ALUSrcB, 0);
      nxt();
      chk("beqt_fetch",  IRWrite, 1);
      chk("beqt_done",   instr_done, 1);
      chk("beqt_ret",    retired, 1);
      Zero = 1'b0;
      nxt(); nxt();
      chk("beqn_pcw",    PCWrite, 0);
      chk("beqn_aluctl", ALUControl, 1);
      nxt();
      chk("beqn_fetch",  IRWrite, 1);
      chk("beqn_done",   instr_done, 1);
      chk("beqn_ret",    retired, 2);

      // ---------------- ALU decode table ----------------
      do_reset(OP_R, 3'b000, 1'b1);
      nxt();
      chk("dec_add_in_decode", ALUControl, 0);
      nxt();
      chk("alu_sub", ALUControl, 1);
      op = OP_I; #1;
      chk("alu_addi_f7", ALUControl, 0);
      op = OP_R; funct3 = 3'b111; #1;
      chk("alu_and", ALUControl, 2);
      funct3 = 3'b010; #1;
      chk("alu_slt", ALUControl, 5);
      funct3 = 3'b110; #1;
      chk("alu_or", ALUControl, 3);
      funct3 = 3'b011; #1;
      chk("alu_other", ALUControl, 0);

      // ---------------- I-type latency ----------------
      do_reset(OP_I, 3'b000, 1'b0);
      fetch_gap(n);
      chk("itype_latency", n, 4);
      chk("itype_ret", retired, 1);

      // ---------------- jal ----------------
      do_reset(OP_JAL, 3'b000, 1'b0);
      chk("jal_imm", ImmSrc, 3);
      nxt(); nxt();
      chk("jal_pcw",   PCWrite, 1);
      chk("jal_srca",  ALUSrcA, 1);
      chk("jal_srcb",  ALUSrcB, 2);
      chk("jal_regwr", RegWrite, 0);
      nxt();
      chk("jal_wb_regwr", RegWrite, 1);
      chk("jal_wb_res",   ResultSrc, 0);
      nxt();
      chk("jal_done", instr_done, 1);
      chk("jal_ret",  retired, 1);

      // ---------------- lw latency ----------------
      do_reset(OP_LW, 3'b010, 1'b0);
      fetch_gap(n);
      chk("lw_latency", n, 5);

      // ---------------- illegal opcode trap ----------------
      do_reset(OP_BAD, 3'b000, 1'b0);
      chk("trap_c0", trap, 0);
      nxt(); nxt();
      chk("trap_set", trap, 1);
      for (int i = 0; i < 20; i++) begin
         nxt();
         chk("trap_sticky", trap, 1);
         chk("trap_enables", {PCWrite, IRWrite, RegWrite, MemWrite}, 0);
         chk("trap_retired", retired, 0);
      end
      #2; RST_N = 1'b0; #1;
      chk("trap_rst_clear", trap, 0);
      @(negedge CLK); RST_N = 1'b1; #1;
      chk("trap_rel_fetch", IRWrite, 1);
      chk("trap_rel_trap",  trap, 0);

      // ---------------- reset mid-store ----------------
      do_reset(OP_SW, 3'b010, 1'b0);
      nxt(); nxt(); nxt();
      chk("sw1_mw", MemWrite, 1);
      nxt();
      chk("sw1_ret", retired, 1);
      nxt(); nxt(); nxt();
      chk("sw2_mw", MemWrite, 1);
      #2; RST_N = 1'b0; #1;
      chk("abort_mw_async", MemWrite, 0);
      chk("abort_ret",      retired, 0);
      chk("abort_irw",      IRWrite, 0);
      @(posedge CLK); #1;
      chk("abort_hold_mw",  MemWrite, 0);
      chk("abort_hold_rw",  RegWrite, 0);
      @(negedge CLK); RST_N = 1'b1; #1;
      chk("abort_fetch",    IRWrite, 1);
      chk("abort_adr",      AdrSrc, 0);
      chk("abort_ret_rel",  retired, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
